// File: rtl/rotacionador_seq.sv
// -----------------------------------------------------------------------------
// rotacionador_seq
//
// Sequential rotator/shifter. A request (operand, direction, amount, mode) is
// taken over a valid/ready handshake, the working register is moved one bit
// position per clock, and the result is held until the consumer takes it.
//
// Handshake rule (both sides): a transfer happens only on a rising clk edge
// where the valid and the matching ready are both 1. Ready never depends
// combinationally on valid, and every output is a register or a decode of
// the state register.
//
// Ports
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   entrada_valida : request fields are valid
//   entrada_pronta : block can accept a request (IDLE only)
//   operando       : value to rotate/shift
//   controle       : 0 = right, 1 = left
//   rotacoes       : number of single-bit steps (0 .. WIDTH-1)
//   modo           : 00 rotate, 01 logical shift, 10 arithmetic shift,
//                    11 rotate
//   saida          : result, valid while saida_valida is high
//   saida_valida   : result available (DONE)
//   saida_pronta   : consumer accepts the result
//   ocupado        : operation in progress or result pending (SHIFT/DONE)
//   estado_dbg     : current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
// -----------------------------------------------------------------------------
module rotacionador_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             entrada_valida,
    output logic             entrada_pronta,
    input  logic [WIDTH-1:0] operando,
    input  logic             controle,
    input  logic [SHW-1:0]   rotacoes,
    input  logic [1:0]       modo,
    output logic [WIDTH-1:0] saida,
    output logic             saida_valida,
    input  logic             saida_pronta,
    output logic             ocupado,
    output logic [1:0]       estado_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } estado_t;

    localparam logic [1:0] MODO_LOGICO     = 2'b01;
    localparam logic [1:0] MODO_ARITMETICO = 2'b10;

    estado_t          state_q, state_d;
    logic [WIDTH-1:0] w_q, w_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [1:0]       modo_q, modo_d;

    // One single-position step of the working register. Modes 00 and 11 both
    // rotate; an arithmetic left shift is the same as a logical left shift.
    function automatic logic [WIDTH-1:0] passo(
        input logic [WIDTH-1:0] w,
        input logic             esquerda,
        input logic [1:0]       m
    );
        logic [WIDTH-1:0] r;
        r = w;
        if (esquerda) begin
            if (m == MODO_LOGICO || m == MODO_ARITMETICO) begin
                r = {w[WIDTH-2:0], 1'b0};
            end else begin
                r = {w[WIDTH-2:0], w[WIDTH-1]};
            end
        end else begin
            if (m == MODO_LOGICO) begin
                r = {1'b0, w[WIDTH-1:1]};
            end else if (m == MODO_ARITMETICO) begin
                r = {w[WIDTH-1], w[WIDTH-1:1]};
            end else begin
                r = {w[0], w[WIDTH-1:1]};
            end
        end
        return r;
    endfunction

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w_q     <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            modo_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            modo_q  <= modo_d;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        modo_d  = modo_q;

        unique case (state_q)
            IDLE: begin
                if (entrada_valida) begin
                    w_d    = operando;
                    dir_d  = controle;
                    modo_d = modo;
                    cnt_d  = rotacoes;
                    // A zero-step request goes straight to DONE holding the operand.
                    state_d = (rotacoes == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                w_d   = passo(w_q, dir_q, modo_q);
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (saida_pronta) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: registers or decodes of state only
    assign entrada_pronta = (state_q == IDLE);
    assign saida_valida   = (state_q == DONE);
    assign ocupado        = (state_q != IDLE);
    assign saida          = w_q;
    assign estado_dbg     = state_q;

endmodule

// File: tb/tb_rotacionador_seq.sv
module tb_rotacionador_seq;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // WIDTH=8 instance
    // ------------------------------------------------------------------
    logic       valid8, ep8, dir8, sv8, sp8, ocup8;
    logic [7:0] op8, saida8;
    logic [2:0] rot8;
    logic [1:0] mode8, est8;

    rotacionador_seq #(.WIDTH(8)) dut8 (
        .clk            (clk),
        .rst_n          (rst_n),
        .entrada_valida (valid8),
        .entrada_pronta (ep8),
        .operando       (op8),
        .controle       (dir8),
        .rotacoes       (rot8),
        .modo           (mode8),
        .saida          (saida8),
        .saida_valida   (sv8),
        .saida_pronta   (sp8),
        .ocupado        (ocup8),
        .estado_dbg     (est8)
    );

    // ------------------------------------------------------------------
    // WIDTH=4 instance (regression of the old combinational shifter)
    // ------------------------------------------------------------------
    logic       valid4, ep4, dir4, sv4, sp4, ocup4;
    logic [3:0] op4, saida4;
    logic [1:0] rot4, mode4, est4;

    rotacionador_seq #(.WIDTH(4)) dut4 (
        .clk            (clk),
        .rst_n          (rst_n),
        .entrada_valida (valid4),
        .entrada_pronta (ep4),
        .operando       (op4),
        .controle       (dir4),
        .rotacoes       (rot4),
        .modo           (mode4),
        .saida          (saida4),
        .saida_valida   (sv4),
        .saida_pronta   (sp4),
        .ocupado        (ocup4),
        .estado_dbg     (est4)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0] op;
        logic       dir;
        logic [2:0] rot;
        logic [1:0] mode;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[11];

    // ------------------------------------------------------------------
    // Driver tasks (drive and sample on the falling edge)
    // ------------------------------------------------------------------
    // Full request on the 8-bit DUT; the request inputs are scrambled every
    // cycle after the accept edge, so the result must come from the capture.
    task automatic do_req8(input logic [7:0] op, input logic dir, input logic [2:0] r,
                           input logic [1:0] m, input logic [7:0] exp, input string tag);
        int         cyc;
        logic [7:0] want;
        @(negedge clk);
        check({tag, "_ready"}, 32'(ep8), 32'd1);
        valid8 = 1'b1; op8 = op; dir8 = dir; rot8 = r; mode8 = m;
        exp_q.push_back(exp);
        @(negedge clk);
        cyc = 0;
        while (!sv8 && cyc < 40) begin
            valid8 = 1'($urandom_range(0, 1));
            op8    = 8'($urandom_range(0, 255));
            dir8   = 1'($urandom_range(0, 1));
            rot8   = 3'($urandom_range(0, 7));
            mode8  = 2'($urandom_range(0, 3));
            @(negedge clk);
            cyc++;
        end
        valid8 = 1'b0;
        check({tag, "_latency"}, 32'(cyc), 32'(r));
        want = exp_q.pop_front();
        check({tag, "_saida"}, 32'(saida8), 32'(want));
        sp8 = 1'b1;
        @(negedge clk);
        sp8 = 1'b0;
        check({tag, "_released"}, 32'(sv8), 32'd0);
    endtask

    task automatic do_req4(input logic [3:0] op, input logic dir, input logic [1:0] r,
                           input logic [3:0] exp, input string tag);
        int cyc;
        @(negedge clk);
        valid4 = 1'b1; op4 = op; dir4 = dir; rot4 = r; mode4 = 2'b00;
        @(negedge clk);
        valid4 = 1'b0;
        cyc = 0;
        while (!sv4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(r));
        check({tag, "_saida"}, 32'(saida4), 32'(exp));
        sp4 = 1'b1;
        @(negedge clk);
        sp4 = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        vecs[0]  = '{op: 8'h96, dir: 1'b0, rot: 3'd3, mode: 2'b00, exp: 8'hD2};
        vecs[1]  = '{op: 8'hE1, dir: 1'b1, rot: 3'd3, mode: 2'b00, exp: 8'h0F};
        vecs[2]  = '{op: 8'h90, dir: 1'b0, rot: 3'd2, mode: 2'b10, exp: 8'hE4};
        vecs[3]  = '{op: 8'h90, dir: 1'b0, rot: 3'd2, mode: 2'b01, exp: 8'h24};
        vecs[4]  = '{op: 8'h81, dir: 1'b1, rot: 3'd1, mode: 2'b01, exp: 8'h02};
        vecs[5]  = '{op: 8'h81, dir: 1'b1, rot: 3'd1, mode: 2'b10, exp: 8'h02};
        vecs[6]  = '{op: 8'h5A, dir: 1'b0, rot: 3'd0, mode: 2'b00, exp: 8'h5A};
        vecs[7]  = '{op: 8'h01, dir: 1'b0, rot: 3'd1, mode: 2'b11, exp: 8'h80};
        vecs[8]  = '{op: 8'hB4, dir: 1'b0, rot: 3'd7, mode: 2'b01, exp: 8'h01};
        vecs[9]  = '{op: 8'hB5, dir: 1'b1, rot: 3'd7, mode: 2'b10, exp: 8'h80};
        vecs[10] = '{op: 8'h4B, dir: 1'b0, rot: 3'd3, mode: 2'b10, exp: 8'h09};

        rst_n  = 1'b0;
        valid8 = 1'b0; op8 = '0; dir8 = 1'b0; rot8 = '0; mode8 = '0; sp8 = 1'b0;
        valid4 = 1'b0; op4 = '0; dir4 = 1'b0; rot4 = '0; mode4 = '0; sp4 = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ready",  32'(ep8),    32'd1);
        check("rst_valida", 32'(sv8),    32'd0);
        check("rst_saida",  32'(saida8), 32'd0);
        check("rst_ocupado", 32'(ocup8), 32'd0);
        check("rst_estado", 32'(est8),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=4 regression
        do_req4(4'b0110, 1'b0, 2'd2, 4'b1001, "w4_rotr2");
        do_req4(4'b1110, 1'b1, 2'd3, 4'b0111, "w4_rotl3");

        // WIDTH=8 table
        for (int i = 0; i < 11; i++) begin
            do_req8(vecs[i].op, vecs[i].dir, vecs[i].rot, vecs[i].mode, vecs[i].exp,
                    $sformatf("vec%0d", i));
        end

        // Backpressure: r=0 request, consumer stalls 5 cycles while another
        // request is offered and must not be taken.
        @(negedge clk);
        valid8 = 1'b1; op8 = 8'h5A; dir8 = 1'b0; rot8 = 3'd0; mode8 = 2'b00;
        @(negedge clk);
        check("bp_valida_r0", 32'(sv8), 32'd1);
        op8 = 8'h33; dir8 = 1'b0; rot8 = 3'd1; mode8 = 2'b00;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_saida_%0d", i),  32'(saida8), 32'h5A);
            check($sformatf("bp_valida_%0d", i), 32'(sv8),    32'd1);
            check($sformatf("bp_ready_%0d", i),  32'(ep8),    32'd0);
            @(negedge clk);
        end
        sp8 = 1'b1;
        @(negedge clk);
        sp8 = 1'b0;
        check("bp_idle_ready",  32'(ep8), 32'd1);
        check("bp_idle_valida", 32'(sv8), 32'd0);
        @(negedge clk);
        valid8 = 1'b0;
        check("bp_new_ocupado", 32'(ocup8), 32'd1);
        check("bp_new_valida",  32'(sv8),   32'd0);
        @(negedge clk);
        check("bp_new_valida2", 32'(sv8),    32'd1);
        check("bp_new_saida",   32'(saida8), 32'h99);
        sp8 = 1'b1;
        @(negedge clk);
        sp8 = 1'b0;

        // Input disturbance on a long rotate
        do_req8(8'hC3, 1'b1, 3'd5, 2'b00, 8'h78, "disturb");

        // Reset two cycles into a r=6 request
        @(negedge clk);
        valid8 = 1'b1; op8 = 8'h0F; dir8 = 1'b1; rot8 = 3'd6; mode8 = 2'b00;
        @(negedge clk);
        valid8 = 1'b0;
        @(negedge clk);
        check("mid_ocupado", 32'(ocup8), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_saida",   32'(saida8), 32'd0);
        check("mid_rst_valida",  32'(sv8),    32'd0);
        check("mid_rst_ocupado", 32'(ocup8),  32'd0);
        check("mid_rst_ready",   32'(ep8),    32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready",  32'(ep8), 32'd1);
        check("post_rst_valida", 32'(sv8), 32'd0);
        do_req8(8'h01, 1'b1, 3'd7, 2'b00, 8'h80, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rotacionador_seq.md
# rotacionador_seq

Parametrised, sequential successor to the combinational 4-bit circular shifter. It accepts an operand, a direction, a shift amount and a mode through a valid/ready handshake, and rotates or shifts the operand one bit position per clock. It holds the result until the consumer accepts it. It sits between an operand-producing datapath stage and a result consumer that may apply backpressure.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥ 2.
- SHW, $clog2(WIDTH), width of the shift-amount port.

Ports (name, direction, width, meaning):
- clk, input, 1, single clock; all state changes on the rising edge.
- rst_n, input, 1, reset, asynchronous and active-low.
- entrada_valida, input, 1, the request fields below are valid.
- entrada_pronta, output, 1, block can accept a request (high only in IDLE).
- operando, input, WIDTH, value to rotate/shift.
- controle, input, 1, 0 = right, 1 = left.
- rotacoes, input, SHW, number of positions (0 … WIDTH-1).
- modo, input, 2, 00 = rotate; 01 = logical shift; 10 = arithmetic shift; 11 = rotate (reserved, behaves as 00).
- saida, output, WIDTH, result; valid while saida_valida is high.
- saida_valida, output, 1, result available.
- saida_pronta, input, 1, consumer accepts the result.
- ocupado, output, 1, high in SHIFT or DONE.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - entrada_pronta = 1.
  - On an edge with entrada_valida=1, capture operando into the working register, capture controle, modo and rotacoes into the step counter.
  - Next state: DONE if rotacoes = 0, else SHIFT.
- SHIFT: each edge applies one single-position step to the working register and decrements the counter. Leave for DONE on the edge where the counter goes 1 → 0.
- Step definitions (W = working register):
  - Rotate right: {W[0], W[WIDTH-1:1]}.
  - Rotate left: {W[WIDTH-2:0], W[WIDTH-1]}.
  - Logical shift: fills with 0.
  - Arithmetic right: fills with W[WIDTH-1].
  - Arithmetic left: identical to logical left.
- DONE:
  - saida_valida = 1; saida = W, stable until accepted.
  - On an edge with saida_pronta=1, go to IDLE.
  - With saida_pronta=0, hold indefinitely.
- Input handling:
  - Inputs are ignored outside the IDLE accept edge.
  - Changes to operando, controle, rotacoes or modo during SHIFT or DONE do not affect the result.
- No request overlap: entrada_pronta is 0 during DONE even when saida_pronta=1 on the same edge. A new request can be accepted one cycle after output acceptance at the earliest.

## Timing
- Reset (asynchronous, rst_n=0):
  - State = IDLE; saida = 0; saida_valida = 0; ocupado = 0; entrada_pronta = 1 (decoded from IDLE); counter and captured controls = 0.
  - Reset asserted mid-SHIFT or mid-DONE discards the operation immediately, with no result emitted.
- Latency: with the accept edge at edge k, saida_valida rises after edge k+r, where r = rotacoes. For r = 0, saida_valida is high in the cycle right after the accept edge.
- Throughput: one request per r+2 cycles with saida_pronta held high (accept, r steps, output accept).
- Outputs are registered or decoded from state only; there is no combinational path from any input to any output.
- Handshake transfer occurs only on a rising edge where valid and ready are both 1.

## Test plan
- WIDTH=4 regression against the old combinational behaviour:
  - 0110, right, rotate, r=2 → saida 1001 after 2 cycles.
  - 1110, left, rotate, r=3 → 0111.
- WIDTH=8, rotate:
  - 0x96, right, r=3 → 0xD2, saida_valida exactly 3 edges after accept.
  - 0xE1, left, r=3 → 0x0F.
- WIDTH=8, shift modes:
  - 0x90, arithmetic right, r=2 → 0xE4.
  - 0x90, logical right, r=2 → 0x24.
  - 0x81, logical left, r=1 → 0x02.
  - 0x81, arithmetic left, r=1 → 0x02.
- r=0 and backpressure:
  - 0x5A, r=0 → saida_valida the cycle after accept, saida 0x5A.
  - Hold saida_pronta=0 for 5 cycles → saida and saida_valida stable, entrada_pronta=0, and a request offered meanwhile is not taken.
  - Release saida_pronta → IDLE, then the offered request is accepted on the following edge.
- Input disturbance: change operando, controle and rotacoes every cycle during SHIFT → result equals the captured request.
- Reset mid-operation: assert rst_n=0 two cycles into a r=6 request → outputs clear asynchronously (before the next clk edge). After release: entrada_pronta=1, saida_valida=0, and a fresh request (0x01, left, rotate, r=7) → 0x80.
